// File: rtl/instr_fetch.sv
// PC register and IF stage: drives the instruction ROM, builds the IF/ID register and takes
// redirects, interrupts and fetch-overflow exceptions. Define IF_PERF_CNT_EN for fetch/bubble counters.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0008,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [30:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        rom_overflow,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        irq,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        xp_we,
    output logic [31:0] xp_data,
    output logic [1:0]  exc_cause
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    typedef enum logic {ST_RUN = 1'b0, ST_TRAP = 1'b1} state_t;

    localparam logic [1:0] CAUSE_IRQ = 2'b01;
    localparam logic [1:0] CAUSE_OVF = 2'b10;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_pc_plus4, w_pc_plus4_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_xp_we, w_xp_we_nxt;
    logic [31:0] r_xp_data, w_xp_data_nxt;
    logic [1:0]  r_cause, w_cause_nxt;

    logic [31:0] w_pc_plus4;
    logic        w_in_run, w_take_exc, w_take_irq;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_in_run   = (r_state == ST_RUN);
    // Traps are only evaluated in RUN, so the TRAP bubble cycle cannot re-trap.
    assign w_take_exc = w_in_run && rom_overflow && !stall;
    assign w_take_irq = w_in_run && irq && !r_pc[31] && !stall;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt     = ST_RUN;
        w_pc_nxt        = r_pc;
        w_instr_nxt     = r_instr;
        w_pc_plus4_nxt  = r_pc_plus4;
        w_valid_nxt     = r_valid;
        w_xp_we_nxt     = 1'b0;
        w_xp_data_nxt   = r_xp_data;
        w_cause_nxt     = r_cause;

        if (w_take_exc) begin
            w_pc_nxt      = EXC_VEC;
            w_instr_nxt   = NOP_INSTR;
            w_valid_nxt   = 1'b0;
            w_xp_we_nxt   = 1'b1;
            w_xp_data_nxt = w_pc_plus4;
            w_cause_nxt   = CAUSE_OVF;
            w_state_nxt   = ST_TRAP;
        end else if (redirect_valid) begin
            w_pc_nxt    = redirect_pc;
            w_instr_nxt = NOP_INSTR;
            w_valid_nxt = 1'b0;
        end else if (w_take_irq) begin
            w_pc_nxt      = IRQ_VEC;
            w_instr_nxt   = NOP_INSTR;
            w_valid_nxt   = 1'b0;
            w_xp_we_nxt   = 1'b1;
            w_xp_data_nxt = w_pc_plus4;
            w_cause_nxt   = CAUSE_IRQ;
            w_state_nxt   = ST_TRAP;
        end else if (!stall) begin
            w_pc_nxt       = w_pc_plus4;
            w_instr_nxt    = rom_data;
            w_pc_plus4_nxt = w_pc_plus4;
            w_valid_nxt    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
            r_xp_we    <= 1'b0;
            r_xp_data  <= 32'd0;
            r_cause    <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_pc_plus4 <= w_pc_plus4_nxt;
            r_valid    <= w_valid_nxt;
            r_xp_we    <= w_xp_we_nxt;
            r_xp_data  <= w_xp_data_nxt;
            r_cause    <= w_cause_nxt;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt, r_bubble_cnt;
    logic        w_hold;

    // A stalled cycle leaves IF/ID untouched and is counted by neither counter.
    assign w_hold = !w_take_exc && !redirect_valid && !w_take_irq && stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else if (!w_hold) begin
            if (w_valid_nxt) r_fetch_cnt  <= r_fetch_cnt + 32'd1;
            else             r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign fetch_cnt  = r_fetch_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

    assign rom_addr       = r_pc[30:0];
    assign pc             = r_pc;
    assign if_id_instr    = r_instr;
    assign if_id_pc_plus4 = r_pc_plus4;
    assign if_id_valid    = r_valid;
    assign xp_we          = r_xp_we;
    assign xp_data        = r_xp_data;
    assign exc_cause      = r_cause;

endmodule
